// File: rtl/serial_tx_pkg.sv
// Shared constants for the serial link: FSM state encoding and line levels.
// The line-level constants are also used by the receiving end.
package serial_tx_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t START  = 3'd1;
  localparam state_t DATA   = 3'd2;
  localparam state_t PARITY = 3'd3;
  localparam state_t STOP   = 3'd4;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/serial_tx_if.sv
// Valid/ready word handshake between a producer and the serial transmitter.
interface serial_tx_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module serial_tx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_end = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Serial frame transmitter: start bit, WIDTH data bits LSB first, stop bit.
// Define TX_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  serial_tx_if.slave  tx,
  output logic        tx_line,
  output logic        busy
);

  localparam int unsigned BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             line_q, line_d;
  logic             ready_q, busy_q;
  logic             bit_end;
`ifdef TX_PARITY_EN
  logic             par_q, par_d;
`endif

  serial_tx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q == IDLE),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef TX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (tx.tx_valid) begin
          state_d   = START;
          shift_d   = tx.tx_data;
          bit_cnt_d = '0;
`ifdef TX_PARITY_EN
          par_d     = ^tx.tx_data;
`endif
        end
      end
      START: if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP: if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Line level is decoded from the next state so the output flop changes on the boundary edge.
  always_comb begin
    line_d = LINE_IDLE;
    case (state_d)
      START:  line_d = LINE_START;
      DATA:   line_d = shift_d[0];
`ifdef TX_PARITY_EN
      PARITY: line_d = par_d;
`endif
      default: line_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      line_q    <= LINE_IDLE;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
`ifdef TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      line_q    <= line_d;
      ready_q   <= (state_d == IDLE);
      busy_q    <= (state_d != IDLE);
`ifdef TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign tx.tx_ready = ready_q;
  assign tx_line     = line_q;
  assign busy        = busy_q;

endmodule
